// File: rtl/rv32imf_obi_arbiter.sv
// Shares one OBI master port between instruction fetch and load/store, routing responses by an in-order owner FIFO.
// Optional build macro RV32IMF_OBI_ARB_ROUND_ROBIN_EN selects round-robin instead of DATA-first priority.
module rv32imf_obi_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   input  logic [31:0] instr_addr_i,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   input  logic [5:0]  data_atop_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        obi_req_o,
   input  logic        obi_gnt_i,
   output logic [31:0] obi_addr_o,
   output logic        obi_we_o,
   output logic [3:0]  obi_be_o,
   output logic [31:0] obi_wdata_o,
   output logic [5:0]  obi_atop_o,
   input  logic [31:0] obi_rdata_i,
   input  logic        obi_rvalid_i,
   input  logic        obi_err_i
);
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic {FREE, LOCKED} state_t;
   typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_t;

   state_t        state, state_nxt;
   owner_t        sel, arb_sel, lock_owner, head;
   owner_t        fifo [MAX_OUTSTANDING];
   logic [CW-1:0] count;
   logic [PW-1:0] wptr, rptr;
   logic          full, sel_req, push, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

`ifdef RV32IMF_OBI_ARB_ROUND_ROBIN_EN
   owner_t last_owner;

   always_comb begin
      arb_sel = OWN_DATA;
      if (instr_req_i && data_req_i)
         arb_sel = (last_owner == OWN_DATA) ? OWN_INSTR : OWN_DATA;
      else if (instr_req_i)
         arb_sel = OWN_INSTR;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    last_owner <= OWN_INSTR;
      else if (push) last_owner <= sel;
   end
`else
   always_comb begin
      arb_sel = OWN_DATA;
      if (instr_req_i && !data_req_i)
         arb_sel = OWN_INSTR;
   end
`endif

   assign full = (count == CW'(MAX_OUTSTANDING));

   // Once a request is presented without grant, the selection is frozen until the bus accepts it.
   always_comb begin
      state_nxt = state;
      sel       = arb_sel;
      sel_req   = instr_req_i | data_req_i;
      if (state == LOCKED) begin
         sel     = lock_owner;
         sel_req = (lock_owner == OWN_DATA) ? data_req_i : instr_req_i;
      end
      obi_req_o = sel_req & ~full;
      case (state)
         FREE:    if (obi_req_o && !obi_gnt_i) state_nxt = LOCKED;
         LOCKED:  if (obi_gnt_i)               state_nxt = FREE;
         default: state_nxt = FREE;
      endcase
   end

   assign obi_addr_o  = (sel == OWN_DATA) ? data_addr_i  : instr_addr_i;
   assign obi_we_o    = (sel == OWN_DATA) & data_we_i;
   assign obi_be_o    = (sel == OWN_DATA) ? data_be_i    : 4'hF;
   assign obi_wdata_o = (sel == OWN_DATA) ? data_wdata_i : '0;
   assign obi_atop_o  = (sel == OWN_DATA) ? data_atop_i  : '0;

   assign push        = obi_req_o & obi_gnt_i;
   assign instr_gnt_o = push & (sel == OWN_INSTR);
   assign data_gnt_o  = push & (sel == OWN_DATA);

   // A response with nothing outstanding has no owner and is discarded.
   assign pop  = obi_rvalid_i & (count != '0);
   assign head = fifo[rptr];

   assign instr_rvalid_o = pop & (head == OWN_INSTR);
   assign data_rvalid_o  = pop & (head == OWN_DATA);
   assign instr_rdata_o  = obi_rdata_i;
   assign data_rdata_o   = obi_rdata_i;
   assign instr_err_o    = obi_err_i;
   assign data_err_o     = obi_err_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FREE;
         lock_owner <= OWN_INSTR;
         count      <= '0;
         wptr       <= '0;
         rptr       <= '0;
      end else begin
         state <= state_nxt;
         if (state == FREE && state_nxt == LOCKED) lock_owner <= sel;
         if (push) wptr <= ptr_inc(wptr);
         if (pop)  rptr <= ptr_inc(rptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo[wptr] <= sel;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n)
         assert (!(obi_rvalid_i && count == '0))
            else $warning("obi response with no outstanding transaction dropped");
   end
`endif
endmodule

// File: tb/tb_rv32imf_obi_arbiter.sv
// Self-checking bench for rv32imf_obi_arbiter: vector table, directed corner sequences, randomized run vs queue model.
module tb_rv32imf_obi_arbiter;
   localparam int MAX = 2;
`ifdef RV32IMF_OBI_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0, rst_n;
   logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_addr_i, instr_rdata_o;
   logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
   logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
   logic [3:0]  data_be_i, obi_be_o;
   logic [5:0]  data_atop_i, obi_atop_o;
   logic        obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i, obi_err_i;
   logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i;

   int checks = 0, failures = 0;

   rv32imf_obi_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
      .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
      .data_atop_i(data_atop_i), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .data_err_o(data_err_o),
      .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
      .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_atop_o(obi_atop_o),
      .obi_rdata_i(obi_rdata_i), .obi_rvalid_i(obi_rvalid_i), .obi_err_i(obi_err_i)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        ir;  logic [31:0] ia;
      logic        dr;  logic [31:0] da; logic dwe;
      logic        gnt; logic rv; logic [31:0] rd; logic err;
      logic        e_req, e_ig, e_dg, e_irv, e_drv;
      logic [31:0] e_addr;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic idle();
      instr_req_i = 0; instr_addr_i = '0;
      data_req_i = 0; data_addr_i = '0; data_we_i = 0; data_be_i = '0; data_wdata_i = '0; data_atop_i = '0;
      obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = '0; obi_err_i = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 0; idle();
      #3;
      @(negedge clk) rst_n = 1;
      next_cycle();
   endtask

   // Behavioural model: owner queue plus lock/last-owner bookkeeping.
   bit q[$];
   bit m_locked, m_lock_own, m_last;

   initial begin
      rst_n = 0; idle();
      #7;
      chk("reset_outputs", {obi_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
                            obi_we_o, obi_be_o, obi_atop_o, obi_addr_o, obi_wdata_o}, '0);
      @(negedge clk) rst_n = 1;
      next_cycle();

      //          ir  ia         dr  da          dwe gnt rv  rd            err  req ig dg irv drv addr
      vecs[0]  = '{0, 32'h0,     0, 32'h200, 0,  0,  0, 32'h0,        0,   0, 0, 0, 0, 0, 32'h200};
      vecs[1]  = '{0, 32'h0,     1, 32'h100, 1,  0,  0, 32'h0,        0,   1, 0, 0, 0, 0, 32'h100};
      vecs[2]  = '{1, 32'h40,    1, 32'h100, 1,  0,  0, 32'h0,        0,   1, 0, 0, 0, 0, 32'h100};
      vecs[3]  = '{1, 32'h40,    1, 32'h100, 1,  0,  0, 32'h0,        0,   1, 0, 0, 0, 0, 32'h100};
      vecs[4]  = '{1, 32'h40,    1, 32'h100, 1,  1,  0, 32'h0,        0,   1, 0, 1, 0, 0, 32'h100};
      vecs[5]  = '{1, 32'h40,    0, 32'h100, 0,  1,  0, 32'h0,        0,   1, 1, 0, 0, 0, 32'h40};
      vecs[6]  = '{1, 32'h44,    0, 32'h100, 0,  1,  0, 32'h0,        0,   0, 0, 0, 0, 0, 32'h44};
      vecs[7]  = '{1, 32'h44,    0, 32'h100, 0,  1,  1, 32'hAAAA0000, 0,   0, 0, 0, 0, 1, 32'h44};
      vecs[8]  = '{1, 32'h44,    0, 32'h100, 0,  1,  1, 32'h5555FFFF, 0,   1, 1, 0, 1, 0, 32'h44};
      vecs[9]  = '{0, 32'h0,     0, 32'h300, 0,  0,  1, 32'h12345678, 1,   0, 0, 0, 1, 0, 32'h300};
      vecs[10] = '{0, 32'h0,     0, 32'h300, 0,  0,  1, 32'hDEADBEEF, 1,   0, 0, 0, 0, 0, 32'h300};
      vecs[11] = '{0, 32'h0,     1, 32'h104, 0,  1,  0, 32'h0,        0,   1, 0, 1, 0, 0, 32'h104};

      for (int i = 0; i < 12; i++) begin
         instr_req_i = vecs[i].ir; instr_addr_i = vecs[i].ia;
         data_req_i = vecs[i].dr; data_addr_i = vecs[i].da; data_we_i = vecs[i].dwe;
         data_be_i = 4'h3; data_wdata_i = 32'hCAFE0000; data_atop_i = 6'h0;
         obi_gnt_i = vecs[i].gnt; obi_rvalid_i = vecs[i].rv; obi_rdata_i = vecs[i].rd; obi_err_i = vecs[i].err;
         @(negedge clk);
         chk($sformatf("vec%0d", i),
             {obi_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, obi_addr_o},
             {vecs[i].e_req, vecs[i].e_ig, vecs[i].e_dg, vecs[i].e_irv, vecs[i].e_drv, vecs[i].e_addr});
         if (vecs[i].rv)
            chk($sformatf("vec%0d_rdata", i), {instr_rdata_o, data_rdata_o, instr_err_o, data_err_o},
                {vecs[i].rd, vecs[i].rd, vecs[i].err, vecs[i].err});
         next_cycle();
      end

      // Conflict: DATA wins first; second round depends on the build.
      do_reset();
      instr_req_i = 1; instr_addr_i = 32'h80; data_req_i = 1; data_addr_i = 32'h180; obi_gnt_i = 1;
      @(negedge clk);
      chk("conflict_first", {instr_gnt_o, data_gnt_o, obi_addr_o}, {2'b01, 32'h180});
      next_cycle();
      @(negedge clk);
      chk("conflict_second", {instr_gnt_o, data_gnt_o, obi_addr_o},
          RR ? {2'b10, 32'h80} : {2'b01, 32'h180});
      next_cycle();
      @(negedge clk);
      chk("throttle_full", {obi_req_o, instr_gnt_o, data_gnt_o}, 3'b000);
      // Asynchronous reset with two outstanding, then a late response.
      #1 rst_n = 0;
      #2 rst_n = 1;
      idle();
      instr_req_i = 1; instr_addr_i = 32'h90; obi_gnt_i = 1; obi_rvalid_i = 1; obi_rdata_i = 32'h1;
      #1;
      chk("after_reset", {obi_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, obi_addr_o},
          {5'b11000, 32'h90});
      next_cycle();

      // Randomized run against the queue model.
      do_reset();
      q.delete(); m_locked = 0; m_lock_own = 0; m_last = 0;
      begin
         bit hold_i = 0, hold_d = 0;
         for (int c = 0; c < 3000; c++) begin
            bit s, r, ok, e_req, e_ig, e_dg, e_irv, e_drv, e_we;
            logic [31:0] e_addr, e_wdata;
            logic [3:0]  e_be;
            logic [5:0]  e_atop;
            if (!hold_i) begin
               instr_req_i = $urandom_range(0, 1); instr_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!hold_d) begin
               data_req_i = $urandom_range(0, 1); data_addr_i = $urandom; data_we_i = $urandom_range(0, 1);
               data_be_i = 4'($urandom); data_wdata_i = $urandom; data_atop_i = 6'($urandom);
            end
            obi_gnt_i = ($urandom_range(0, 3) != 0);
            obi_rvalid_i = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            obi_rdata_i = $urandom; obi_err_i = $urandom_range(0, 1);

            if (m_locked) begin
               s = m_lock_own;
               r = s ? data_req_i : instr_req_i;
            end else begin
               r = instr_req_i | data_req_i;
               if (instr_req_i && data_req_i) s = RR ? ~m_last : 1'b1;
               else                           s = ~instr_req_i;
            end
            e_req = r && (q.size() < MAX);
            e_ig = e_req && obi_gnt_i && !s;
            e_dg = e_req && obi_gnt_i && s;
            ok = obi_rvalid_i && (q.size() > 0);
            e_irv = ok && (q[0] == 1'b0);
            e_drv = ok && (q[0] == 1'b1);
            e_addr  = s ? data_addr_i : instr_addr_i;
            e_we    = s && data_we_i;
            e_be    = s ? data_be_i : 4'hF;
            e_wdata = s ? data_wdata_i : 32'h0;
            e_atop  = s ? data_atop_i : 6'h0;

            @(negedge clk);
            chk("rand_ctrl", {obi_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
                              obi_we_o, obi_be_o, obi_atop_o},
                {e_req, e_ig, e_dg, e_irv, e_drv, e_we, e_be, e_atop});
            chk("rand_addr", obi_addr_o, e_addr);
            chk("rand_wdata", obi_wdata_o, e_wdata);
            if (ok)
               chk("rand_rdata", {instr_rdata_o, data_rdata_o, instr_err_o, data_err_o},
                   {obi_rdata_i, obi_rdata_i, obi_err_i, obi_err_i});

            if (ok) void'(q.pop_front());
            if (e_req && obi_gnt_i) begin
               q.push_back(s);
               m_last = s;
            end
            if (!m_locked && e_req && !obi_gnt_i) begin
               m_locked = 1; m_lock_own = s;
            end else if (m_locked && obi_gnt_i) begin
               m_locked = 0;
            end
            hold_i = instr_req_i && !e_ig;
            hold_d = data_req_i && !e_dg;
            next_cycle();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
